uart_loop_buf: RTL and testbench

//  Buffered UART loopback controller: sits between the UART RX deframer and the

---
 rtl/uart_loop_pkg.sv | 32 +++
 rtl/uart_loop_buf_sync_fifo.sv | 65 ++++++
 rtl/uart_loop_buf.sv | 105 ++++++++++
 tb/tb_uart_loop_buf.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loop_pkg.sv
// Shared definitions for the UART loopback buffer: mode codes, TX FSM states
// and the per-byte transform applied when a word leaves the FIFO.
package uart_loop_pkg;

    localparam logic [1:0] MODE_ECHO  = 2'd0;
    localparam logic [1:0] MODE_CASE  = 2'd1;
    localparam logic [1:0] MODE_INV   = 2'd2;
    localparam logic [1:0] MODE_PAUSE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd2
    } tx_state_e;

    // Case swap only touches ASCII letters; every other code passes unchanged.
    function automatic logic [7:0] xform_byte(input logic [7:0] b, input logic [1:0] mode);
        logic [7:0] r;
        r = b;
        case (mode)
            MODE_CASE: begin
                if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
                    r = b ^ 8'h20;
                end
            end
            MODE_INV: r = ~b;
            default:  r = b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_loop_buf_sync_fifo.sv
// Registered-pointer synchronous FIFO; full/empty come from the occupancy count
// so the pointers can simply wrap.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [ADDR_W:0]   level_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once level is 0.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_loop_buf.sv
// Buffered UART loopback: RX bytes are queued, transformed at pop time and
// replayed to the TX framer through a req/busy handshake.
module uart_loop_buf
    import uart_loop_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              valid_in,
    input  logic              tx_busy,
    input  logic [1:0]        mode,
    input  logic              clr_ovf,
    output logic              tx_req,
    output logic [DATA_W-1:0] byte_out,
    output logic [ADDR_W:0]   level,
    output logic              ovf
);

    tx_state_e         state_q;
    logic              tx_req_q;
    logic [DATA_W-1:0] byte_out_q;
    logic              ovf_q, ovf_d;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;

    // Upper bits beyond the low byte pass through except in invert mode.
    function automatic logic [DATA_W-1:0] xform_word(input logic [DATA_W-1:0] w,
                                                     input logic [1:0] m);
        logic [DATA_W-1:0] xf;
        xf      = w;
        xf[7:0] = xform_byte(w[7:0], m);
        if (m == MODE_INV) xf = ~w;
        return xf;
    endfunction

    assign push = valid_in && !full;
    assign pop  = (state_q == ST_IDLE) && !empty && (mode != MODE_PAUSE) && !tx_busy;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (byte_in),
        .pop_i   (pop),
        .head_o  (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // Overflow wins over a simultaneous clear so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)           ovf_d = 1'b0;
        if (valid_in && full)  ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            tx_req_q   <= 1'b0;
            byte_out_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        byte_out_q <= xform_word(head, mode);
                        tx_req_q   <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tx_busy) begin
                        tx_req_q <= 1'b0;
                        state_q  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!tx_busy) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tx_req   = tx_req_q;
    assign byte_out = byte_out_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_loop_buf.sv
// Scoreboard bench for uart_loop_buf: expected TX bytes are queued as RX bytes
// are driven and popped as the bench plays the TX framer side of the handshake.
module tb_uart_loop_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic [7:0] byteIn = '0;
    logic       validIn = 1'b0;
    logic       txBusy = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       clrOvf = 1'b0;
    logic       txReq;
    logic [7:0] byteOut;
    logic [4:0] level;
    logic       ovf;

    int total = 0;
    int bad = 0;
    logic [7:0] expQ[$];

    uart_loop_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .byte_in  (byteIn),
        .valid_in (validIn),
        .tx_busy  (txBusy),
        .mode     (mode),
        .clr_ovf  (clrOvf),
        .tx_req   (txReq),
        .byte_out (byteOut),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelXform(input logic [7:0] b, input logic [1:0] m);
        if (m == 2'd2) return ~b;
        if (m == 2'd1) begin
            if (b >= 8'd65 && b <= 8'd90)  return b + 8'd32;
            if (b >= 8'd97 && b <= 8'd122) return b - 8'd32;
        end
        return b;
    endfunction

    task automatic applyStimulus(input logic [7:0] b);
        byteIn  = b;
        validIn = 1'b1;
        tick();
        validIn = 1'b0;
    endtask

    // Acts as the TX framer for one frame: wait for req, check the byte, then busy.
    task automatic serveFrame(input int reqDelay, input int busyCycles);
        int waited;
        logic [7:0] want;
        waited = 0;
        while (txReq !== 1'b1 && waited < 60) begin
            tick();
            waited++;
        end
        total++;
        if (txReq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL frame_req: tx_req=%b required 1 within %0d cycles", txReq, waited);
            return;
        end
        want = 8'h00;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL frame_extra: unexpected frame byte_out=%h", byteOut);
        end else begin
            want = expQ.pop_front();
            if (byteOut !== want) begin
                bad++;
                $display("[TB] FAIL frame_data: byte_out=%h required %h", byteOut, want);
            end
        end
        repeat (reqDelay) tick();
        total++;
        if (txReq !== 1'b1 || byteOut !== want) begin
            bad++;
            $display("[TB] FAIL req_hold: tx_req=%b byte_out=%h required 1/%h", txReq, byteOut, want);
        end
        txBusy = 1'b1;
        tick();
        total++;
        if (txReq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL req_drop: tx_req=%b required 0", txReq);
        end
        repeat (busyCycles) tick();
        txBusy = 1'b0;
        tick();
    endtask

    task automatic checkQuiet(input int cycles, input string tag);
        logic sawReq;
        sawReq = 1'b0;
        repeat (cycles) begin
            tick();
            if (txReq !== 1'b0) sawReq = 1'b1;
        end
        total++;
        if (sawReq || level !== 5'd0 || expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s_quiet: req_seen=%b level=%0d pending=%0d required 0/0/0",
                     tag, sawReq, level, expQ.size());
        end
    endtask

    task automatic test_reset();
        #1 rstN = 1'b0;
        repeat (3) tick();
        total++;
        if (txReq !== 1'b0 || byteOut !== 8'h00 || level !== 5'd0 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: req=%b out=%h level=%0d ovf=%b required 0/00/0/0",
                     txReq, byteOut, level, ovf);
        end
        rstN = 1'b1;
        tick();
    endtask

    task automatic test_single();
        mode = 2'd0;
        expQ.push_back(modelXform(8'h41, 2'd0));
        applyStimulus(8'h41);
        total++;
        if (level !== 5'd1 || txReq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_push: level=%0d req=%b required 1/0", level, txReq);
        end
        tick();
        total++;
        if (txReq !== 1'b1 || level !== 5'd0) begin
            bad++;
            $display("[TB] FAIL single_latency: req=%b level=%0d required 1/0", txReq, level);
        end
        serveFrame(10, 3);
        checkQuiet(5, "single");
    endtask

    task automatic test_burst_case();
        int peak;
        peak = 0;
        mode = 2'd1;
        for (int i = 0; i < 5; i++) expQ.push_back(modelXform(8'h61 + 8'(i), 2'd1));
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    byteIn  = 8'h61 + 8'(i);
                    validIn = 1'b1;
                    tick();
                    if (int'(level) > peak) peak = int'(level);
                end
                validIn = 1'b0;
            end
            begin
                repeat (5) serveFrame(1, 2);
            end
        join
        total++;
        if (peak < 4 || peak > 5) begin
            bad++;
            $display("[TB] FAIL burst_peak: peak level=%0d required 4..5", peak);
        end
        checkQuiet(4, "burst");
        mode = 2'd0;
    endtask

    task automatic test_overflow();
        mode   = 2'd0;
        txBusy = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i < DEPTH) expQ.push_back(8'h10 + 8'(i));
            byteIn  = 8'h10 + 8'(i);
            validIn = 1'b1;
            tick();
        end
        validIn = 1'b0;
        total++;
        if (level !== 5'(DEPTH) || ovf !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ovf_full: level=%0d ovf=%b required %0d/1", level, ovf, DEPTH);
        end
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        total++;
        if (ovf !== 1'b0 || level !== 5'(DEPTH)) begin
            bad++;
            $display("[TB] FAIL ovf_clear: ovf=%b level=%0d required 0/%0d", ovf, level, DEPTH);
        end
        byteIn  = 8'hF0;
        validIn = 1'b1;
        clrOvf  = 1'b1;
        tick();
        validIn = 1'b0;
        clrOvf  = 1'b0;
        total++;
        if (ovf !== 1'b1 || level !== 5'(DEPTH)) begin
            bad++;
            $display("[TB] FAIL ovf_vs_clear: ovf=%b level=%0d required 1/%0d", ovf, level, DEPTH);
        end
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
        txBusy = 1'b0;
        repeat (DEPTH) serveFrame(0, 1);
        checkQuiet(4, "ovf");
    endtask

    task automatic test_pause_modes();
        logic sawReq;
        int waited;
        mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(modelXform(8'h31 + 8'(i), 2'd0));
            applyStimulus(8'h31 + 8'(i));
        end
        sawReq = 1'b0;
        repeat (8) begin
            tick();
            if (txReq !== 1'b0) sawReq = 1'b1;
        end
        total++;
        if (sawReq || level !== 5'd3) begin
            bad++;
            $display("[TB] FAIL pause_hold: req_seen=%b level=%0d required 0/3", sawReq, level);
        end
        mode = 2'd0;
        repeat (3) serveFrame(2, 1);
        mode = 2'd2;
        expQ.push_back(modelXform(8'h5A, 2'd2));
        applyStimulus(8'h5A);
        serveFrame(1, 1);
        mode = 2'd1;
        expQ.push_back(modelXform(8'h61, 2'd1));
        applyStimulus(8'h61);
        waited = 0;
        while (txReq !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        mode = 2'd2;
        tick();
        total++;
        if (byteOut !== 8'h41) begin
            bad++;
            $display("[TB] FAIL mode_change_hold: byte_out=%h required 41", byteOut);
        end
        serveFrame(1, 1);
        mode = 2'd0;
        checkQuiet(4, "pause");
    endtask

    task automatic test_full_push_pop();
        mode   = 2'd0;
        txBusy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            expQ.push_back(8'h80 + 8'(i));
            applyStimulus(8'h80 + 8'(i));
        end
        byteIn  = 8'hEE;
        validIn = 1'b1;
        txBusy  = 1'b0;
        tick();
        validIn = 1'b0;
        total++;
        if (level !== 5'(DEPTH - 1) || ovf !== 1'b1 || txReq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_push_pop: level=%0d ovf=%b req=%b required %0d/1/1",
                     level, ovf, txReq, DEPTH - 1);
        end
        repeat (DEPTH) serveFrame(0, 1);
        checkQuiet(4, "fullpp");
        clrOvf = 1'b1;
        tick();
        clrOvf = 1'b0;
    endtask

    task automatic test_reset_mid();
        mode   = 2'd0;
        txBusy = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus(8'hC0 + 8'(i));
        total++;
        if (txReq !== 1'b1 || level !== 5'd4) begin
            bad++;
            $display("[TB] FAIL midrst_setup: req=%b level=%0d required 1/4", txReq, level);
        end
        #2 rstN = 1'b0;
        #1;
        total++;
        if (txReq !== 1'b0 || level !== 5'd0 || byteOut !== 8'h00 || ovf !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_async: req=%b level=%0d out=%h ovf=%b required 0/0/00/0",
                     txReq, level, byteOut, ovf);
        end
        #3 rstN = 1'b1;
        tick();
        expQ.delete();
        expQ.push_back(8'h7E);
        applyStimulus(8'h7E);
        serveFrame(3, 2);
        checkQuiet(4, "midrst");
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_case();
        test_overflow();
        test_pause_modes();
        test_full_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
